vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Single-port framebuffer arbiter between the VGA scan-out path and a pixel writer. Each clock it grants the framebuffer RAM port to either a display read, derived from the visible-pixel coordinates of the VGA timing generator, or a buffered write from an upstream producer such as a drawing engine or UART loader. Display reads always win. Writes queue in an internal FIFO and drain only on cycles with no display read. The block sits between the VGA timing driver, the framebuffer BRAM and the pixel output stage.

## Interface
Parameters:
- H_ACTIVE, 1024: visible pixels per line.
- V_ACTIVE, 768: visible lines per frame.
- ADDR_W, 20: framebuffer address width. Must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- DATA_W, 12: pixel width (RGB444).
- WFIFO_DEPTH, 16: write FIFO entries. Power of two, >= 2.
- RAM_LAT, 1: framebuffer read latency in cycles, from the registered address to ram_rdata valid.

Ports:
- clk_vga  in  1  pixel clock; sole clock.
- rst  in  1  reset, synchronous and active-high.
- hc_visible  in  11  horizontal visible coordinate. 0 = not visible; 1..H_ACTIVE = pixel x+1.
- vc_visible  in  11  vertical visible coordinate. 0 = not visible; 1..V_ACTIVE = line y+1.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept the request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- ram_addr  out  ADDR_W  framebuffer address (registered).
- ram_we  out  1  write enable (registered).
- ram_wdata  out  DATA_W  write data (registered).
- ram_rdata  in  DATA_W  read data.
- pix_valid  out  1  pix_data is a fetched pixel.
- pix_data  out  DATA_W  pixel to DAC. 0 when pix_valid=0.
- err_oob  out  1  sticky flag: an out-of-range write was dropped.
- fifo_level  out  $clog2(WFIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Visible condition:** vis = (1 <= hc_visible <= H_ACTIVE) && (1 <= vc_visible <= V_ACTIVE). Coordinates outside these ranges count as not visible.
- **Display address:** (vc_visible-1)*H_ACTIVE + (hc_visible-1), computed at full width, then truncated to ADDR_W.
- **Write intake:** a handshake completes when wr_valid && wr_ready. wr_ready = !full; it does not depend on wr_valid or on the pop on the same cycle.
- **Out-of-range writes:** if wr_addr >= H_ACTIVE*V_ACTIVE, the handshake still completes, but the entry is not pushed and err_oob is set. err_oob is cleared only by rst.
- **Port FSM.** States are IDLE, RD and WR. The state names the operation driven on the RAM port during the next cycle. Next state each cycle:
  - vis → RD. ram_addr = display address, ram_we = 0.
  - else if the FIFO is non-empty → WR. Pop the head; ram_addr/ram_wdata = head, ram_we = 1.
  - else → IDLE. ram_we = 0; ram_addr and ram_wdata hold their values.
- **No conflicts:** a write is never issued on a cycle already claimed by a display read.
- **Pixel return:** a RD cycle's ram_rdata is registered into pix_data with pix_valid=1. Every other cycle drives pix_data=0, pix_valid=0.
- **FIFO:** circular, with read/write pointers one bit wider than the index. When push and pop happen on the same cycle, the level is unchanged. Pointers wrap modulo WFIFO_DEPTH.
- **Write order:** writes leave the FIFO in order. Two queued writes to the same address are both performed, and the last one wins.
- **Reset:** rst on any cycle, including mid-line or mid-drain:
  - FIFO emptied; queued writes are discarded.
  - State goes to IDLE.
  - ram_we, ram_addr, ram_wdata, pix_valid, pix_data, err_oob and fifo_level all go to 0.
  - wr_ready = 1 in the first cycle after rst deasserts.

## Timing
- Visible coordinate sampled at edge t → ram_addr valid after edge t+1 → ram_rdata at t+1+RAM_LAT → pix_valid/pix_data after edge t+2+RAM_LAT. The total display latency is RAM_LAT+2 cycles (3 with the default). The output stage delays hs/vs to match.
- A handshake accepted at edge t is visible in fifo_level after t. The entry is eligible for popping at edge t+1 at the earliest, so with a free port, ram_we=1 after edge t+1.
- Write throughput:
  - One write per non-visible cycle.
  - Zero during the visible portion of a visible line.
  - Horizontal and vertical blanking drain the FIFO at one entry per cycle.
- When the FIFO is full, wr_ready is low. It rises in the cycle after the first pop.

## Test plan
- **Reset:** hold rst 3 cycles with wr_valid=1 → all outputs 0, wr_ready=1 after release, no RAM write during reset.
- **Display read:** hc_visible=5, vc_visible=3 → ram_addr=2*1024+4=2052 and ram_we=0 one cycle later. ram_rdata=0xABC returned → pix_data=0xABC, pix_valid=1, 3 cycles after the coordinate.
- **Write during active video:** push 20 writes with continuous wr_valid during active video → 16 accepted, then wr_ready=0 and fifo_level=16. No ram_we=1 while vis. At blanking, 16 consecutive write cycles in order, then wr_ready recovers one cycle after the first pop.
- **Out-of-range write:** wr_addr=786432 → handshake completes, fifo_level unchanged, err_oob=1 and remains set until rst.
- **Simultaneous push and pop:** level 4 during blanking with one accept per cycle → level stays 4 while data drains in FIFO order. Level 16 (full) with wr_valid=1 → no accept that cycle even though a pop occurs.
- **Reset mid-drain:** assert rst with fifo_level=10 → level 0 next cycle, ram_we=0, and none of the 10 queued writes ever reach the RAM.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: VGA display reads always win; pixel writes queue in
// a FIFO and drain on cycles with no display read.
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned WFIFO_DEPTH = 16,
  parameter int unsigned RAM_LAT     = 1
) (
  input  logic                             clk_vga,
  input  logic                             rst,
  input  logic [10:0]                      hc_visible,
  input  logic [10:0]                      vc_visible,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [ADDR_W-1:0]                ram_addr,
  output logic                             ram_we,
  output logic [DATA_W-1:0]                ram_wdata,
  input  logic [DATA_W-1:0]                ram_rdata,
  output logic                             pix_valid,
  output logic [DATA_W-1:0]                pix_data,
  output logic                             err_oob,
  output logic [$clog2(WFIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned PTR_W   = $clog2(WFIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned FB_SIZE = H_ACTIVE * V_ACTIVE;
  localparam logic [10:0] H_MAX   = 11'(H_ACTIVE);
  localparam logic [10:0] V_MAX   = 11'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t          fifo_mem [WFIFO_DEPTH];
  wr_entry_t          head;
  logic [PTR_W:0]     wptr;
  logic [PTR_W:0]     rptr;
  state_t             state;
  logic               rd_now;
  logic [RAM_LAT-1:0] rd_pipe;
  logic [ADDR_W-1:0]  disp_addr;
  logic               vis;
  logic               full;
  logic               empty;
  logic               accept;
  logic               in_range;
  logic               push;

  assign vis = (hc_visible != 11'd0) && (hc_visible <= H_MAX) &&
               (vc_visible != 11'd0) && (vc_visible <= V_MAX);

  // Only meaningful when vis, so the -1 never underflows.
  assign disp_addr = ADDR_W'(32'(vc_visible - 11'd1) * H_ACTIVE +
                             32'(hc_visible - 11'd1));

  assign fifo_level = wptr - rptr;
  assign full       = (fifo_level == LVL_W'(WFIFO_DEPTH));
  assign empty      = (wptr == rptr);
  assign wr_ready   = !full;
  assign accept     = wr_valid && !full;
  assign in_range   = (32'(wr_addr) < FB_SIZE);
  assign push       = accept && in_range;
  assign head       = fifo_mem[rptr[PTR_W-1:0]];
  assign rd_now     = (state == RD);

  always_ff @(posedge clk_vga) begin
    if (push) fifo_mem[wptr[PTR_W-1:0]] <= '{addr: wr_addr, data: wr_data};
  end

  // Port FSM: state names the operation on the RAM port during the next cycle.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_pipe   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      err_oob   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + LVL_W'(1);
      if (accept && !in_range) err_oob <= 1'b1;

      if (vis) begin
        state    <= RD;
        ram_addr <= disp_addr;
        ram_we   <= 1'b0;
      end else if (!empty) begin
        state     <= WR;
        rptr      <= rptr + LVL_W'(1);
        ram_addr  <= head.addr;
        ram_wdata <= head.data;
        ram_we    <= 1'b1;
      end else begin
        state  <= IDLE;
        ram_we <= 1'b0;
      end

      // Track which RAM cycles were reads so their data lands on the pixel output.
      rd_pipe   <= RAM_LAT'({rd_pipe, rd_now});
      pix_valid <= rd_pipe[RAM_LAT-1];
      pix_data  <= rd_pipe[RAM_LAT-1] ? ram_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: sync-read RAM model plus a log of RAM writes.
module tb_vga_fb_arbiter;

  logic        clk_vga = 1'b0;
  logic        rst;
  logic [10:0] hc_visible, vc_visible;
  logic        wr_valid, wr_ready;
  logic [19:0] wr_addr;
  logic [11:0] wr_data;
  logic [19:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        err_oob;
  logic [4:0]  fifo_level;

  int n_cmp = 0;
  int n_mis = 0;
  int conflicts = 0;
  logic vis_q = 1'b0;
  logic [19:0] wl_addr [$];
  logic [11:0] wl_data [$];

  vga_fb_arbiter dut (
    .clk_vga(clk_vga), .rst(rst), .hc_visible(hc_visible), .vc_visible(vc_visible),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_valid(pix_valid), .pix_data(pix_data), .err_oob(err_oob), .fifo_level(fifo_level)
  );

  always #5 clk_vga = ~clk_vga;

  // RAM model: one-cycle registered read; address 2052 (0x804) returns 0xABC.
  always @(posedge clk_vga) begin
    ram_rdata <= 12'(ram_addr) ^ 12'h2B8;
    if (ram_we) begin
      wl_addr.push_back(ram_addr);
      wl_data.push_back(ram_wdata);
      if (vis_q) conflicts++;
    end
    vis_q <= (hc_visible >= 11'd1) && (hc_visible <= 11'd1024) &&
             (vc_visible >= 11'd1) && (vc_visible <= 11'd768);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_data.delete();
  endtask

  // Queue n writes at base.. while the display is reading.
  task automatic fill_visible(input int n, input int base);
    hc_visible = 11'd1;
    vc_visible = 11'd1;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 20'(base + i);
      wr_data  = 12'(base + i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int accepted;
    logic rdy;

    rst = 1'b1; hc_visible = '0; vc_visible = '0;
    wr_valid = 1'b1; wr_addr = 20'd7; wr_data = 12'h123;

    // Reset held 3 cycles with a pending write
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_we", 32'(ram_we), 32'd0);
    end
    check_eq("rst_addr",  32'(ram_addr),   32'd0);
    check_eq("rst_wdata", 32'(ram_wdata),  32'd0);
    check_eq("rst_pixv",  32'(pix_valid),  32'd0);
    check_eq("rst_pixd",  32'(pix_data),   32'd0);
    check_eq("rst_oob",   32'(err_oob),    32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    wr_valid = 1'b0;
    rst = 1'b0;
    tick();
    check_eq("rst_ready", 32'(wr_ready),   32'd1);
    check_eq("rst_level2", 32'(fifo_level), 32'd0);
    check_eq("rst_nowrite", 32'(wl_addr.size()), 32'd0);

    // Display read at x=4, y=2
    hc_visible = 11'd5; vc_visible = 11'd3;
    tick();
    check_eq("rd_addr", 32'(ram_addr), 32'd2052);
    check_eq("rd_we",   32'(ram_we),   32'd0);
    hc_visible = 11'd0; vc_visible = 11'd0;
    tick();
    check_eq("rd_pixv_early", 32'(pix_valid), 32'd0);
    tick();
    check_eq("rd_pixv", 32'(pix_valid), 32'd1);
    check_eq("rd_pixd", 32'(pix_data),  32'hABC);
    tick();
    check_eq("rd_pixv_after", 32'(pix_valid), 32'd0);
    check_eq("rd_pixd_after", 32'(pix_data),  32'd0);

    // 20 writes offered during active video: 16 fit
    clear_log();
    accepted = 0;
    vc_visible = 11'd10;
    for (int c = 0; c < 20; c++) begin
      hc_visible = 11'(1 + c);
      wr_valid = 1'b1;
      wr_addr  = 20'(100 + accepted);
      wr_data  = 12'(12'h100 + accepted);
      rdy = wr_ready;
      tick();
      if (rdy) accepted++;
    end
    wr_valid = 1'b0;
    check_eq("full_accepted", 32'(accepted),   32'd16);
    check_eq("full_ready",    32'(wr_ready),   32'd0);
    check_eq("full_level",    32'(fifo_level), 32'd16);
    check_eq("full_nowrite",  32'(wl_addr.size()), 32'd0);
    hc_visible = 11'd0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq("drain_we",    32'(ram_we),    32'd1);
      check_eq("drain_addr",  32'(ram_addr),  32'(100 + k));
      check_eq("drain_wdata", 32'(ram_wdata), 32'(12'h100 + k));
      if (k == 0) begin
        check_eq("drain_ready", 32'(wr_ready),   32'd1);
        check_eq("drain_level", 32'(fifo_level), 32'd15);
      end
    end
    tick();
    check_eq("drain_done_we",    32'(ram_we),     32'd0);
    check_eq("drain_done_level", 32'(fifo_level), 32'd0);
    check_eq("no_conflict",      32'(conflicts),  32'd0);

    // Out-of-range write is accepted but dropped
    clear_log();
    wr_valid = 1'b1; wr_addr = 20'd786432; wr_data = 12'hFFF;
    check_eq("oob_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    check_eq("oob_level", 32'(fifo_level), 32'd0);
    check_eq("oob_flag",  32'(err_oob),    32'd1);
    for (int i = 0; i < 3; i++) tick();
    check_eq("oob_sticky",  32'(err_oob),         32'd1);
    check_eq("oob_nowrite", 32'(wl_addr.size()),  32'd0);

    // Level 4 held steady by one push and one pop per blanking cycle
    clear_log();
    fill_visible(4, 200);
    check_eq("pp_level_init", 32'(fifo_level), 32'd4);
    hc_visible = 11'd0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 20'(204 + i);
      wr_data  = 12'(204 + i);
      tick();
      check_eq("pp_level", 32'(fifo_level), 32'd4);
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("pp_count", 32'(wl_addr.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < wl_addr.size()) begin
        check_eq("pp_order_addr", 32'(wl_addr[i]), 32'(200 + i));
        check_eq("pp_order_data", 32'(wl_data[i]), 32'(200 + i));
      end
    end

    // Full FIFO with a pop on the same edge: no accept that cycle
    clear_log();
    fill_visible(16, 500);
    check_eq("fp_level_full", 32'(fifo_level), 32'd16);
    hc_visible = 11'd0;
    wr_valid = 1'b1; wr_addr = 20'd300; wr_data = 12'h300;
    tick();
    wr_valid = 1'b0;
    check_eq("fp_level", 32'(fifo_level), 32'd15);
    check_eq("fp_ready", 32'(wr_ready),   32'd1);
    check_eq("fp_we",    32'(ram_we),     32'd1);
    check_eq("fp_addr",  32'(ram_addr),   32'd500);
    for (int i = 0; i < 17; i++) tick();
    check_eq("fp_count", 32'(wl_addr.size()), 32'd16);
    check_eq("fp_last",  32'(wl_addr[wl_addr.size()-1]), 32'd515);

    // Reset mid-drain discards queued writes and clears err_oob
    check_eq("pre_rst_oob", 32'(err_oob), 32'd1);
    fill_visible(10, 400);
    check_eq("md_level", 32'(fifo_level), 32'd10);
    clear_log();
    hc_visible = 11'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("md_level0", 32'(fifo_level), 32'd0);
    check_eq("md_we",     32'(ram_we),     32'd0);
    check_eq("md_oob",    32'(err_oob),    32'd0);
    for (int i = 0; i < 12; i++) tick();
    check_eq("md_ready",   32'(wr_ready),        32'd1);
    check_eq("md_nowrite", 32'(wl_addr.size()),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
